// File: rtl/sim_mailbox_pkg.sv
// rtl/sim_mailbox_pkg.sv - register offsets, STATUS layout and shared types for the simulation mailbox
package sim_mailbox_pkg;

  localparam logic [1:0] OFF_CONSOLE = 2'd0;
  localparam logic [1:0] OFF_STATUS  = 2'd1;
  localparam logic [1:0] OFF_EXIT    = 2'd2;
  localparam logic [1:0] OFF_CLR     = 2'd3;

  localparam int STATUS_EMPTY_BIT = 0;
  localparam int STATUS_FULL_BIT  = 1;
  localparam int STATUS_COUNT_LSB = 8;

  localparam logic [31:0] COUNTER_MAX = 32'hFFFF_FFFF;

  // Captured address-phase attributes carried into the data phase.
  typedef struct packed {
    logic       valid;
    logic       write;
    logic       in_win;
    logic [1:0] off;
  } dphase_t;

  function automatic logic [31:0] status_word(input logic [7:0] count,
                                              input logic       full,
                                              input logic       empty);
    logic [31:0] w;
    w = '0;
    w[STATUS_COUNT_LSB +: 8] = count;
    w[STATUS_FULL_BIT]       = full;
    w[STATUS_EMPTY_BIT]      = empty;
    return w;
  endfunction

endpackage

// File: rtl/sim_char_fifo.sv
// rtl/sim_char_fifo.sv - byte FIFO feeding the console sink; full/empty/count come from a registered count
module sim_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [7:0]                 data_i,
  input  logic                       pop_i,
  output logic [7:0]                 data_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_q];

  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= data_i;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/sim_mailbox_ctrl.sv
// rtl/sim_mailbox_ctrl.sv - AHB-Lite slave for the simulation mailbox: cycle counter, console FIFO, test exit
module sim_mailbox_ctrl
  import sim_mailbox_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h2001FFF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        sysclk,
  input  logic        sysrst_b,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic [1:0]  htrans,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic [31:0] hrdata,
  output logic        hresp,
  output logic        char_vld,
  output logic [7:0]  char_data,
  input  logic        char_rdy,
  output logic        sim_done,
  output logic [7:0]  sim_code
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  dphase_t       dp_q, dp_d;
  logic [31:0]   counter_q, counter_d;
  logic          done_q, done_d;
  logic [7:0]    code_q, code_d;
  logic          fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [7:0]    fifo_head;
  logic          console_stall, wr_done, push, pop;
  logic          unused_ok;

  assign unused_ok = ^{hsize, htrans[0], haddr[1:0], hwdata[31:8]};

  assign console_stall = dp_q.valid & dp_q.write & dp_q.in_win &
                         (dp_q.off == OFF_CONSOLE) & fifo_full;
  assign hreadyout = ~console_stall;
  assign hresp     = 1'b0;
  assign wr_done   = dp_q.valid & dp_q.write & dp_q.in_win & ~console_stall;
  assign push      = wr_done & (dp_q.off == OFF_CONSOLE);
  assign pop       = char_vld & char_rdy;
  assign char_vld  = ~fifo_empty;
  assign char_data = fifo_head;
  assign sim_done  = done_q;
  assign sim_code  = code_q;

  always_comb begin
    dp_d = dp_q;
    if (hready) begin
      dp_d.valid  = hsel & htrans[1];
      dp_d.write  = hwrite;
      dp_d.in_win = (haddr[31:4] == BASE_ADDR[31:4]);
      dp_d.off    = haddr[3:2];
    end
  end

  // Clear beats increment; the counter sticks at all-ones rather than wrapping.
  always_comb begin
    if (wr_done && dp_q.off == OFF_CLR)  counter_d = '0;
    else if (counter_q == COUNTER_MAX)   counter_d = counter_q;
    else                                 counter_d = counter_q + 32'd1;
  end

  always_comb begin
    done_d = done_q;
    code_d = code_q;
    if (wr_done && dp_q.off == OFF_EXIT && !done_q) begin
      done_d = 1'b1;
      code_d = hwdata[7:0];
    end
  end

  always_comb begin
    hrdata = '0;
    if (dp_q.valid && !dp_q.write && dp_q.in_win) begin
      case (dp_q.off)
        OFF_CONSOLE: hrdata = counter_q;
        OFF_STATUS:  hrdata = status_word(8'(fifo_count), fifo_full, fifo_empty);
        default:     hrdata = '0;
      endcase
    end
  end

  always_ff @(posedge sysclk) begin
    if (!sysrst_b) begin
      dp_q      <= '0;
      counter_q <= '0;
      done_q    <= 1'b0;
      code_q    <= 8'h00;
    end else begin
      dp_q      <= dp_d;
      counter_q <= counter_d;
      done_q    <= done_d;
      code_q    <= code_d;
    end
  end

  sim_char_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (sysclk),
    .rst_ni  (sysrst_b),
    .push_i  (push),
    .data_i  (hwdata[7:0]),
    .pop_i   (pop),
    .data_o  (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

endmodule

// File: doc/sim_mailbox_ctrl.md
# sim_mailbox_ctrl

AHB-Lite slave that owns the simulation mailbox window at 0x2001FFF0 and arbitrates CPU accesses to a free-running cycle counter, a character console and a test-exit register. Sits on the CPU main AHB bus (m2 path) in the SoC testbench top. It replaces ad-hoc forcing of bus read data with a proper slave: console writes queue into a byte FIFO drained by a ready/valid sink, and wait states are inserted when the FIFO is full.

## Interface
- BASE_ADDR, 32'h2001FFF0, window base; 16-byte aligned, decode on haddr[31:4]
- FIFO_DEPTH, 8, console FIFO entries; power of two, >= 2
- sysclk  in  1  bus clock
- sysrst_b  in  1  reset; synchronous, active-low
- hsel  in  1  slave select
- haddr  in  32  address
- htrans  in  2  transfer type; only NONSEQ/SEQ (htrans[1]=1) start a transfer
- hwrite  in  1  1 = write
- hsize  in  3  transfer size; not checked
- hwdata  in  32  write data, valid in data phase
- hready  in  1  bus-wide ready
- hreadyout  out  1  slave ready; reset 1
- hrdata  out  32  read data; reset 0
- hresp  out  1  always 0 (OKAY)
- char_vld  out  1  FIFO head valid; reset 0
- char_data  out  8  FIFO head byte; reset 0
- char_rdy  in  1  sink accepts head
- sim_done  out  1  sticky exit flag; reset 0
- sim_code  out  8  exit code; reset 0

## Operation
- Address phase accepted when hsel & hready & htrans[1]; latch offset haddr[3:2], hwrite, and in-window flag (haddr[31:4]==BASE_ADDR[31:4]). Out-of-window selects: zero-wait OKAY, reads 0, writes ignored.
- Register map (offset): 0x0 read = COUNTER, write = CONSOLE push hwdata[7:0]; 0x4 read = STATUS {fifo_count[7:0] at [15:8], full [1], empty [0]}, write ignored; 0x8 write = EXIT, read 0; 0xC write = COUNTER_CLR, read 0.
- COUNTER: 32-bit, +1 every cycle, saturates at 32'hFFFFFFFF (no wrap). COUNTER_CLR completing in a cycle makes next value 0 (clear wins over increment).
- CONSOLE: write data phase stalls (hreadyout=0) while FIFO full; completes the first cycle full=0, pushing hwdata[7:0].
- FIFO: char_vld = !empty, char_data = head; pop on char_vld & char_rdy. Push and pop same cycle: count unchanged. Full decision uses registered count, so pop while full releases the stall the following cycle.
- EXIT: first completed write sets sim_done=1, sim_code=hwdata[7:0]; later EXIT writes ignored until reset.
- Reset: FIFO emptied, pending data phase discarded, counter 0, sim_done/sim_code cleared, hreadyout=1.

## Timing
- Reads zero-wait: address phase cycle N, data phase N+1, hrdata = register value during N+1 (COUNTER returns count at N plus 1).
- Writes zero-wait except CONSOLE-on-full; stall length = cycles until a pop occurs, +1.
- Console latency: push at end of data-phase cycle N+1 -> char_vld high in N+2 if FIFO was empty.
- Back-to-back pipelined transfers supported; a new address phase is only taken when hready=1.
- hrdata driven 0 outside read data phases.

## Structure
- Package sim_mailbox_pkg: offset constants (OFF_CONSOLE, OFF_STATUS, OFF_EXIT, OFF_CLR), STATUS bit positions, saturating max constant.
- Sub-module sim_char_fifo (8-bit, FIFO_DEPTH, push/pop, full/empty/count outputs); top holds AHB phase tracking, counter, exit logic.

## Test plan
- Reset, idle 10 cycles, read 0x2001FFF0 -> hrdata = count value during data phase (e.g. 12 if address phase at cycle 11 after reset release), zero wait.
- char_rdy=1, write 0x48,0x69 to 0x2001FFF0 back-to-back -> char_vld pulses with char_data 0x48 then 0x69, no stalls.
- char_rdy=0, 9 CONSOLE writes with FIFO_DEPTH=8 -> STATUS reads count 8, full=1; 9th write holds hreadyout=0; raise char_rdy one cycle -> 9th completes next cycle, count stays 8.
- Write 0x2001FFFC then read COUNTER -> small value (1 or 2); force counter to 32'hFFFFFFFE -> reads saturate at 32'hFFFFFFFF.
- EXIT write 0x5A then 0xA5 -> sim_done=1, sim_code=0x5A held.
- Assert sysrst_b=0 during a stalled CONSOLE write -> next cycle hreadyout=1, char_vld=0, STATUS count 0.
